hs_ram_arbiter: RTL and testbench
=================================

Name: hs_ram_arbiter

Overview:
Arbitrates the game core's shared work-RAM port between the CPU and the hiscore engine.
- The CPU owns the port by default.
- A hiscore request makes the block raise pause_req to the pause system and wait for the CPU-paused acknowledge.
- After a settle interval it hands the RAM to the hiscore engine, serves single-cycle read/write accesses, then releases the pause and returns the port to the CPU.
- It sits between FPGA_NINJAKUN's RAM, the hiscore module and the pause module, all on clk_sys.

Parameters:
AW, 16, RAM address width.
DW, 8, RAM data width.
SETTLE, 2, clk_sys cycles between paused=1 and the first hiscore grant (CPU bus drain). Range 1..15.
TIMEOUT, 4095, clk_sys cycles to wait for paused before flagging hs_err. 0 disables the timeout.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU RAM access strobe (level, one access per cycle)
cpu_we  in  1  CPU write enable
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data
cpu_ack  out  1  CPU access complete
hs_req  in  1  hiscore access request (ram_intent_read|ram_intent_write)
hs_we  in  1  hiscore write enable
hs_addr  in  AW  hiscore address
hs_wdata  in  DW  hiscore write data
hs_rdata  out  DW  hiscore read data
hs_ack  out  1  hiscore access complete
vblank  in  1  vertical blank from HVGEN
paused  in  1  CPU-halted acknowledge from the pause system
pause_req  out  1  pause request to the pause system
ram_addr  out  AW  to RAM
ram_we  out  1  to RAM
ram_wdata  out  DW  to RAM
ram_rdata  in  DW  from RAM (synchronous, 1-cycle read latency)
hs_busy  out  1  hiscore owns the port, or is acquiring it
hs_err  out  1  sticky error: pause timeout or CPU access during hiscore ownership

Behaviour:
Reset values:
- Outputs 0. rdata registers 0. State IDLE. Counters 0.
- Async assert, sync-deasserted usage assumed upstream.

FSM states: IDLE, PAUSE_WAIT, SETTLE, GRANT, RELEASE.
- IDLE:
  - RAM mux selects CPU.
  - hs_req=1 -> PAUSE_WAIT. pause_req=1 and hs_busy=1 registered on the next edge.
- PAUSE_WAIT:
  - Hold pause_req. Timeout counter increments.
  - paused=1 -> SETTLE, counter cleared.
  - Counter reaches TIMEOUT (when TIMEOUT≠0) -> set hs_err, go RELEASE.
  - hs_req dropping here -> RELEASE.
- SETTLE:
  - Count SETTLE cycles, then GRANT.
  - paused dropping -> back to PAUSE_WAIT.
- GRANT:
  - RAM mux selects hiscore.
  - Each cycle with hs_req=1 and no access in flight issues ram_addr/ram_we/ram_wdata.
  - Next cycle: hs_ack=1 for one cycle, with hs_rdata=ram_rdata on reads. Writes ack identically.
  - Maximum throughput is 1 access per 2 cycles.
  - hs_req=0 with no access in flight -> RELEASE.
  - paused dropping mid-GRANT -> any in-flight access is still acked; then PAUSE_WAIT with pause_req held.
- RELEASE:
  - pause_req=0 and hs_busy=0, one cycle, then IDLE.
  - hs_req re-asserted in RELEASE is taken from IDLE on the following cycle.

CPU path:
- In IDLE/PAUSE_WAIT/SETTLE/RELEASE the RAM is CPU-driven combinationally.
- cpu_ack=1 the cycle after cpu_req, with cpu_rdata registered from ram_rdata.
- In GRANT, cpu_req is ignored: no ack, ram_we forced from hiscore only, and hs_err is set.

Other rules:
- ram_we is never asserted by both requesters in the same cycle.
- hs_err clears only on reset.
- Widths are fixed; no arithmetic on data. Counters saturate.

Optional Feature:
Macro HS_VBLANK_SYNC_EN.
- Defined: the IDLE->PAUSE_WAIT transition also requires the rising edge of vblank (registered vblank 0->1). hs_req is held pending until that edge, so pauses begin only at frame blank.
- Undefined: vblank is ignored and transition is immediate on hs_req.

Test Plan:
- Reset: reset_n=0 mid-GRANT with an access in flight -> all outputs 0 immediately. After release, CPU read addr 0x1234 acked 1 cycle later.
- CPU-only: cpu_req read of 0x0100 (RAM=0x5A) -> cpu_ack next cycle, cpu_rdata=0x5A. pause_req stays 0.
- Full hiscore sequence (SETTLE=2):
  - hs_req -> pause_req next cycle.
  - paused raised 3 cycles later -> first ram_addr=hs_addr 2 cycles after paused.
  - Write 0xA5 to 0xE000, then read back -> hs_ack pulses, hs_rdata=0xA5.
  - hs_req low -> pause_req low within 2 cycles.
- Timeout (TIMEOUT=16): hs_req with paused held 0 -> hs_err=1 at cycle 17, pause_req deasserts, FSM back to IDLE.
- Conflict and unpause:
  - cpu_req during GRANT -> no cpu_ack, hs_err=1, RAM contents at cpu_addr unchanged.
  - paused dropped mid-GRANT -> in-flight hs_ack still delivered, FSM in PAUSE_WAIT.
- HS_VBLANK_SYNC_EN defined: hs_req at line 100 -> pause_req held 0 until the vblank rising edge, asserted the cycle after.

Source files
------------

// File: rtl/hs_ram_arbiter.sv
// Shares the work-RAM port between the CPU (default owner) and the hiscore engine, pausing the CPU first.
// Optional HS_VBLANK_SYNC_EN: hiscore acquisition starts only on a registered vblank rising edge.
module hs_ram_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          hs_req,
  input  logic          hs_we,
  input  logic [AW-1:0] hs_addr,
  input  logic [DW-1:0] hs_wdata,
  output logic [DW-1:0] hs_rdata,
  output logic          hs_ack,
  input  logic          vblank,
  input  logic          paused,
  output logic          pause_req,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          hs_busy,
  output logic          hs_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAUSE_WAIT,
    ST_SETTLE,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_MAX      = '1;
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start;
  logic          timeout_hit;
  logic          hs_issue;
  logic          cpu_issue;
  logic          cpu_conflict;
  logic          busy_d;
  logic          hs_ack_rd, cpu_ack_rd;
  logic [DW-1:0] hs_rd_q, cpu_rd_q;

`ifdef HS_VBLANK_SYNC_EN
  logic vblank_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) vblank_q <= 1'b0;
    else          vblank_q <= vblank;
  end

  assign start = hs_req & vblank & ~vblank_q;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign start = hs_req;
`endif

  // One hiscore access per two cycles: never issue during the ack cycle.
  assign hs_issue     = (state_q == ST_GRANT) && hs_req && paused && !hs_ack;
  assign cpu_issue    = cpu_req && (state_q != ST_GRANT);
  assign cpu_conflict = cpu_req && (state_q == ST_GRANT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = ST_PAUSE_WAIT;
      end
      ST_PAUSE_WAIT: begin
        if (!hs_req) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (paused) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST)) begin
          timeout_hit = 1'b1;
          state_d     = ST_RELEASE;
          cnt_d       = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!paused) begin
          state_d = ST_PAUSE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d = ST_GRANT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GRANT: begin
        // Losing the pause always wins; a pending ack is a register and still fires.
        if (!paused) begin
          state_d = ST_PAUSE_WAIT;
          cnt_d   = '0;
        end else if (!hs_req && !hs_ack) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_d = (state_d == ST_PAUSE_WAIT) || (state_d == ST_SETTLE) || (state_d == ST_GRANT);

  always_comb begin
    ram_addr  = cpu_addr;
    ram_we    = cpu_issue & cpu_we;
    ram_wdata = cpu_wdata;
    if (state_q == ST_GRANT) begin
      ram_addr  = hs_addr;
      ram_we    = hs_issue & hs_we;
      ram_wdata = hs_wdata;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pause_req  <= 1'b0;
      hs_busy    <= 1'b0;
      hs_err     <= 1'b0;
      hs_ack     <= 1'b0;
      hs_ack_rd  <= 1'b0;
      hs_rd_q    <= '0;
      cpu_ack    <= 1'b0;
      cpu_ack_rd <= 1'b0;
      cpu_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pause_req  <= busy_d;
      hs_busy    <= busy_d;
      hs_err     <= hs_err | timeout_hit | cpu_conflict;
      hs_ack     <= hs_issue;
      hs_ack_rd  <= hs_issue & ~hs_we;
      cpu_ack    <= cpu_issue;
      cpu_ack_rd <= cpu_issue & ~cpu_we;
      if (hs_ack_rd)  hs_rd_q  <= ram_rdata;
      if (cpu_ack_rd) cpu_rd_q <= ram_rdata;
    end
  end

  // Read data is live from the RAM during the ack cycle and held afterwards.
  assign hs_rdata  = hs_ack_rd  ? ram_rdata : hs_rd_q;
  assign cpu_rdata = cpu_ack_rd ? ram_rdata : cpu_rd_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Scoreboard bench for hs_ram_arbiter: directed scenarios push expected acks, a negedge monitor pops them.
module tb_hs_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;

  typedef struct {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, hs_req, hs_we, vblank, paused;
  logic [AW-1:0] cpu_addr, hs_addr, ram_addr;
  logic [DW-1:0] cpu_wdata, hs_wdata, cpu_rdata, hs_rdata, ram_wdata, ram_rdata;
  logic          cpu_ack, hs_ack, pause_req, ram_we, hs_busy, hs_err;

  logic [DW-1:0] mem [0:65535];
  exp_t          cpu_q[$];
  exp_t          hs_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  hs_ram_arbiter #(.AW(AW), .DW(DW), .SETTLE(2), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_wdata(hs_wdata),
    .hs_rdata(hs_rdata), .hs_ack(hs_ack),
    .vblank(vblank), .paused(paused), .pause_req(pause_req),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .hs_busy(hs_busy), .hs_err(hs_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [AW-1:0] c_addr,
                                input logic [DW-1:0] c_wdata, input logic h_req, input logic h_we,
                                input logic [AW-1:0] h_addr, input logic [DW-1:0] h_wdata);
    cpu_req   = c_req;
    cpu_we    = c_we;
    cpu_addr  = c_addr;
    cpu_wdata = c_wdata;
    hs_req    = h_req;
    hs_we     = h_we;
    hs_addr   = h_addr;
    hs_wdata  = h_wdata;
  endtask

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (cpu_ack) begin
        n_checks++;
        if (cpu_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL cpu_ack_unexpected: got ack, expected none at %0t", $time);
        end else begin
          exp_t e;
          e = cpu_q.pop_front();
          if (!e.we && cpu_rdata !== e.data) begin
            n_fail++;
            $display("[TB] FAIL cpu_rdata: got 0x%0h, expected 0x%0h at %0t", cpu_rdata, e.data, $time);
          end
        end
      end
      if (hs_ack) begin
        n_checks++;
        if (hs_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL hs_ack_unexpected: got ack, expected none at %0t", $time);
        end else begin
          exp_t e;
          e = hs_q.pop_front();
          if (!e.we && hs_rdata !== e.data) begin
            n_fail++;
            $display("[TB] FAIL hs_rdata: got 0x%0h, expected 0x%0h at %0t", hs_rdata, e.data, $time);
          end
        end
      end
    end
  end

  initial begin
    mem[16'h0100] <= 8'h5A;
    mem[16'h1234] <= 8'h77;
    reset_n = 1'b0;
    vblank  = 1'b0;
    paused  = 1'b0;
    apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0);
    #2;
    check_output("reset_pause_req", pause_req, 0);
    check_output("reset_hs_busy", hs_busy, 0);
    check_output("reset_hs_err", hs_err, 0);
    check_output("reset_acks", {cpu_ack, hs_ack}, 0);
    #20 reset_n = 1'b1;
    tick();

    $display("[TB] CPU-only read");
    apply_stimulus(1, 0, 16'h0100, '0, 0, 0, '0, '0);
    cpu_q.push_back('{we: 1'b0, data: 8'h5A});
    tick();
    apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0);
    check_output("cpu_ack_next_cycle", cpu_ack, 1);
    check_output("cpu_only_pause_req", pause_req, 0);
    tick();
    check_output("cpu_ack_one_cycle", cpu_ack, 0);

    $display("[TB] Full hiscore sequence");
    apply_stimulus(0, 0, '0, '0, 1, 1, 16'hE000, 8'hA5);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    check_output("seq_pause_req_up", pause_req, 1);
    check_output("seq_hs_busy_up", hs_busy, 1);
    tick();
    tick();
    paused = 1'b1;
    tick();
    tick();
    check_output("seq_no_early_grant_we", ram_we, 0);
    check_output("seq_no_early_grant_addr", ram_addr, 16'h0000);
    tick();
    check_output("seq_grant_addr", ram_addr, 16'hE000);
    check_output("seq_grant_we", ram_we, 1);
    hs_q.push_back('{we: 1'b1, data: 8'h00});
    tick();
    check_output("seq_write_ack", hs_ack, 1);
    hs_we = 1'b0;
    hs_q.push_back('{we: 1'b0, data: 8'hA5});
    tick();
    check_output("seq_read_we", ram_we, 0);
    tick();
    check_output("seq_read_ack", hs_ack, 1);
    check_output("seq_read_data", hs_rdata, 8'hA5);
    hs_req = 1'b0;
    tick();
    tick();
    check_output("seq_pause_req_down", pause_req, 0);
    check_output("seq_hs_busy_down", hs_busy, 0);
    check_output("seq_no_err", hs_err, 0);
    paused = 1'b0;
    tick();

    $display("[TB] Conflict and unpause");
    apply_stimulus(0, 0, '0, '0, 1, 0, 16'hE000, '0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    paused = 1'b1;
    tick();
    tick();
    tick();
    hs_q.push_back('{we: 1'b0, data: 8'hA5});
    apply_stimulus(1, 1, 16'h0100, 8'hFF, 1, 0, 16'hE000, '0);
    check_output("conflict_ram_we", ram_we, 0);
    tick();
    check_output("conflict_no_cpu_ack", cpu_ack, 0);
    check_output("conflict_hs_err", hs_err, 1);
    apply_stimulus(0, 0, '0, '0, 1, 0, 16'hE000, '0);
    tick();
    hs_q.push_back('{we: 1'b0, data: 8'hA5});
    tick();
    check_output("unpause_inflight_ack", hs_ack, 1);
    paused = 1'b0;
    tick();
    check_output("unpause_pause_req_held", pause_req, 1);
    check_output("unpause_ack_done", hs_ack, 0);
    check_output("unpause_cpu_mux", ram_addr, 16'h0000);
    check_output("conflict_mem_intact", mem[16'h0100], 8'h5A);

    $display("[TB] Reset mid-grant");
    paused = 1'b1;
    tick();
    tick();
    tick();
    check_output("regrant_addr", ram_addr, 16'hE000);
    #2;
    reset_n = 1'b0;
    paused  = 1'b0;
    apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0);
    #1;
    check_output("rst_pause_req", pause_req, 0);
    check_output("rst_hs_busy", hs_busy, 0);
    check_output("rst_hs_err", hs_err, 0);
    check_output("rst_hs_ack", hs_ack, 0);
    check_output("rst_ram", {ram_we, ram_addr, ram_wdata}, 0);
    check_output("rst_rdata", {hs_rdata, cpu_rdata}, 0);
    tick();
    tick();
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    apply_stimulus(1, 0, 16'h1234, '0, 0, 0, '0, '0);
    cpu_q.push_back('{we: 1'b0, data: 8'h77});
    tick();
    apply_stimulus(0, 0, '0, '0, 0, 0, '0, '0);
    check_output("post_reset_cpu_ack", cpu_ack, 1);
    tick();

    $display("[TB] Pause timeout");
    hs_req = 1'b1;
    vblank = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      vblank = 1'b0;
      if (i == 16) begin
        check_output("timeout_err_not_yet", hs_err, 0);
        check_output("timeout_pause_held", pause_req, 1);
      end
    end
    tick();
    check_output("timeout_err_set", hs_err, 1);
    check_output("timeout_pause_drop", pause_req, 0);
    hs_req = 1'b0;
    tick();
    tick();
    check_output("timeout_idle_pause", pause_req, 0);
    check_output("timeout_idle_busy", hs_busy, 0);
    check_output("timeout_err_sticky", hs_err, 1);

`ifdef HS_VBLANK_SYNC_EN
    $display("[TB] Vblank-synchronised start");
    hs_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("vblank_wait", pause_req, 0);
    end
    vblank = 1'b1;
    tick();
    check_output("vblank_start", pause_req, 1);
    hs_req = 1'b0;
    vblank = 1'b0;
    tick();
    tick();
`endif

    tick();
    check_output("cpu_queue_drained", cpu_q.size(), 0);
    check_output("hs_queue_drained", hs_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
